// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bus: retiring-instruction fields and data memory response in,
// register file write port and pipeline control out.
interface mem_wb_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              MEM_Valid;
    logic              MEM_Reg_Write;
    logic [REG_AW-1:0] MEM_RD_Addr;
    logic [1:0]        MEM_WB_Sel;
    logic [DATA_W-1:0] MEM_ALU_Result;
    logic [DATA_W-1:0] MEM_PC_Plus4;
    logic [2:0]        MEM_Load_Funct3;
    logic              MEM_IRQ;
    logic [DATA_W-1:0] DMEM_RData;
    logic              DMEM_RValid;
    logic              Flush;
    logic              Ext_Freeze;

    logic [REG_AW-1:0] RD_Write_Addr;
    logic [DATA_W-1:0] RD_Write_Data;
    logic              Reg_Write_Enable__EX_MEM;
    logic              WB_Ctrl__IRQ;
    logic              MEM_WB_Freeze;
    logic              Stall_Req;
    logic              Load_Misaligned;

    modport master (
        output MEM_Valid, MEM_Reg_Write, MEM_RD_Addr, MEM_WB_Sel, MEM_ALU_Result,
               MEM_PC_Plus4, MEM_Load_Funct3, MEM_IRQ, DMEM_RData, DMEM_RValid,
               Flush, Ext_Freeze,
        input  RD_Write_Addr, RD_Write_Data, Reg_Write_Enable__EX_MEM, WB_Ctrl__IRQ,
               MEM_WB_Freeze, Stall_Req, Load_Misaligned
    );

    modport slave (
        input  MEM_Valid, MEM_Reg_Write, MEM_RD_Addr, MEM_WB_Sel, MEM_ALU_Result,
               MEM_PC_Plus4, MEM_Load_Funct3, MEM_IRQ, DMEM_RData, DMEM_RValid,
               Flush, Ext_Freeze,
        output RD_Write_Addr, RD_Write_Data, Reg_Write_Enable__EX_MEM, WB_Ctrl__IRQ,
               MEM_WB_Freeze, Stall_Req, Load_Misaligned
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback stage: captures retiring instructions, aligns/extends load
// data, drives the register file write port and stalls while a load is outstanding.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic            CLK,
    input logic            RST,
    mem_wb_stage_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    localparam logic [1:0] SelLoad = 2'b01;
    localparam logic [1:0] SelPc   = 2'b10;
    localparam logic [2:0] F3Lb    = 3'b000;
    localparam logic [2:0] F3Lh    = 3'b001;
    localparam logic [2:0] F3Lbu   = 3'b100;
    localparam logic [2:0] F3Lhu   = 3'b101;

    function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] word,
                                                     input logic [1:0]        off,
                                                     input logic [2:0]        f3);
        logic [DATA_W-1:0] shifted;
        logic [7:0]        b;
        logic [15:0]       h;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3Lb:    align_load = {{(DATA_W-8){b[7]}}, b};
            F3Lh:    align_load = {{(DATA_W-16){h[15]}}, h};
            F3Lbu:   align_load = {{(DATA_W-8){1'b0}}, b};
            F3Lhu:   align_load = {{(DATA_W-16){1'b0}}, h};
            default: align_load = word;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [REG_AW-1:0] ctx_rd_q, ctx_rd_d;
    logic [2:0]        ctx_f3_q, ctx_f3_d;
    logic [1:0]        ctx_off_q, ctx_off_d;
    logic              ctx_irq_q, ctx_irq_d;
    logic              ctx_we_q, ctx_we_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              discard_q, discard_d;
    logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_en_q, wb_en_d;
    logic              wb_irq_q, wb_irq_d;
    logic              mis_q, mis_d;

    logic              is_load;
    logic [1:0]        off;
    logic              is_byte, is_half, misaligned;
    logic              rvalid_eff;
    logic [DATA_W-1:0] rdata_eff;
    logic              stall;

    assign is_load    = (bus.MEM_WB_Sel == SelLoad);
    assign off        = bus.MEM_ALU_Result[1:0];
    assign is_byte    = (bus.MEM_Load_Funct3 == F3Lb) || (bus.MEM_Load_Funct3 == F3Lbu);
    assign is_half    = (bus.MEM_Load_Funct3 == F3Lh) || (bus.MEM_Load_Funct3 == F3Lhu);
    assign misaligned = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
    // A response captured during freeze stands in for DMEM_RValid once released.
    assign rvalid_eff = bus.DMEM_RValid || hold_valid_q;
    assign rdata_eff  = hold_valid_q ? hold_data_q : bus.DMEM_RData;

    always_comb begin
        stall = 1'b0;
        if (state_q == StLoadWait) begin
            stall = !rvalid_eff;
        end else begin
            stall = bus.MEM_Valid && is_load && !misaligned && !bus.Flush &&
                    (!bus.DMEM_RValid || discard_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        ctx_rd_d     = ctx_rd_q;
        ctx_f3_d     = ctx_f3_q;
        ctx_off_d    = ctx_off_q;
        ctx_irq_d    = ctx_irq_q;
        ctx_we_d     = ctx_we_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        discard_d    = discard_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        wb_en_d      = wb_en_q;
        wb_irq_d     = wb_irq_q;
        mis_d        = 1'b0;

        // The stale response of a flushed load retires the discard flag.
        if (discard_q && bus.DMEM_RValid) begin
            discard_d = 1'b0;
        end

        if (bus.Flush) begin
            wb_en_d      = 1'b0;
            state_d      = StIdle;
            hold_valid_d = 1'b0;
            if (state_q == StLoadWait && !rvalid_eff) begin
                discard_d = 1'b1;
            end
        end else if (bus.Ext_Freeze) begin
            if (state_q == StLoadWait && bus.DMEM_RValid && !hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_data_d  = bus.DMEM_RData;
            end
        end else begin
            wb_en_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.MEM_Valid) begin
                        if (!is_load) begin
                            wb_addr_d = bus.MEM_RD_Addr;
                            wb_irq_d  = bus.MEM_IRQ;
                            wb_data_d = (bus.MEM_WB_Sel == SelPc) ? bus.MEM_PC_Plus4
                                                                  : bus.MEM_ALU_Result;
                            wb_en_d   = bus.MEM_Reg_Write && (bus.MEM_RD_Addr != '0);
                        end else if (misaligned) begin
                            mis_d = 1'b1;
                        end else if (!discard_q) begin
                            if (bus.DMEM_RValid) begin
                                wb_addr_d = bus.MEM_RD_Addr;
                                wb_irq_d  = bus.MEM_IRQ;
                                wb_data_d = align_load(bus.DMEM_RData, off, bus.MEM_Load_Funct3);
                                wb_en_d   = bus.MEM_Reg_Write && (bus.MEM_RD_Addr != '0);
                            end else begin
                                ctx_rd_d  = bus.MEM_RD_Addr;
                                ctx_f3_d  = bus.MEM_Load_Funct3;
                                ctx_off_d = off;
                                ctx_irq_d = bus.MEM_IRQ;
                                ctx_we_d  = bus.MEM_Reg_Write;
                                state_d   = StLoadWait;
                            end
                        end
                    end
                end
                StLoadWait: begin
                    if (rvalid_eff) begin
                        wb_addr_d    = ctx_rd_q;
                        wb_irq_d     = ctx_irq_q;
                        wb_data_d    = align_load(rdata_eff, ctx_off_q, ctx_f3_q);
                        wb_en_d      = ctx_we_q && (ctx_rd_q != '0);
                        hold_valid_d = 1'b0;
                        state_d      = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            ctx_rd_q     <= '0;
            ctx_f3_q     <= '0;
            ctx_off_q    <= '0;
            ctx_irq_q    <= 1'b0;
            ctx_we_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            discard_q    <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            wb_en_q      <= 1'b0;
            wb_irq_q     <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctx_rd_q     <= ctx_rd_d;
            ctx_f3_q     <= ctx_f3_d;
            ctx_off_q    <= ctx_off_d;
            ctx_irq_q    <= ctx_irq_d;
            ctx_we_q     <= ctx_we_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            discard_q    <= discard_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            wb_en_q      <= wb_en_d;
            wb_irq_q     <= wb_irq_d;
            mis_q        <= mis_d;
        end
    end

    assign bus.RD_Write_Addr            = wb_addr_q;
    assign bus.RD_Write_Data            = wb_data_q;
    assign bus.Reg_Write_Enable__EX_MEM = wb_en_q;
    assign bus.WB_Ctrl__IRQ             = wb_irq_q;
    assign bus.Load_Misaligned          = mis_q;
    assign bus.MEM_WB_Freeze            = bus.Ext_Freeze;
    assign bus.Stall_Req                = stall;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed corner cases plus randomized
// transactions scored against a behavioural load/write-back model.
module tb_mem_wb_stage;
    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.MEM_Valid   = 1'b0;
        bus.DMEM_RValid = 1'b0;
        bus.Flush       = 1'b0;
        bus.Ext_Freeze  = 1'b0;
        bus.DMEM_RData  = $urandom;
    endtask

    task automatic drive_mem(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                             input logic [31:0] alu, input logic [31:0] pc,
                             input logic [2:0] f3, input logic irq);
        bus.MEM_Valid       = 1'b1;
        bus.MEM_Reg_Write   = we;
        bus.MEM_RD_Addr     = rd;
        bus.MEM_WB_Sel      = sel;
        bus.MEM_ALU_Result  = alu;
        bus.MEM_PC_Plus4    = pc;
        bus.MEM_Load_Funct3 = f3;
        bus.MEM_IRQ         = irq;
    endtask

    // Reference: access size from funct3, then pick/extend with plain arithmetic.
    function automatic int unsigned load_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int unsigned ofs;
        logic [31:0] bv, hv;
        ofs = addr % 4;
        bv  = (word >> (8 * ofs)) & 32'hFF;
        hv  = (word >> (16 * (ofs / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (bv >= 128) ? bv - 32'd256 : bv;
            3'd1:    return (hv >= 32768) ? hv - 32'd65536 : hv;
            3'd4:    return bv;
            3'd5:    return hv;
            default: return word;
        endcase
    endfunction

    task automatic do_nonload(input string tag, input logic we, input logic [4:0] rd,
                              input logic [1:0] sel, input logic [31:0] alu,
                              input logic [31:0] pc, input logic irq);
        logic [31:0] exp_data;
        exp_data = (sel == 2'b10) ? pc : alu;
        drive_mem(we, rd, sel, alu, pc, 3'($urandom), irq);
        bus.DMEM_RValid = 1'($urandom);
        #4 check({tag, ".stall"}, 32'(bus.Stall_Req), 0);
        cycle();
        idle();
        check({tag, ".addr"}, 32'(bus.RD_Write_Addr), 32'(rd));
        check({tag, ".data"}, bus.RD_Write_Data, exp_data);
        check({tag, ".en"}, 32'(bus.Reg_Write_Enable__EX_MEM), 32'(we && rd != 0));
        check({tag, ".irq"}, 32'(bus.WB_Ctrl__IRQ), 32'(irq));
        cycle();
        check({tag, ".en_off"}, 32'(bus.Reg_Write_Enable__EX_MEM), 0);
    endtask

    task automatic do_load(input string tag, input logic we, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input int lat, input logic irq);
        bit misal;
        misal = (addr % load_size(f3)) != 0;
        drive_mem(we, rd, 2'b01, addr, $urandom, f3, irq);
        if (misal) begin
            bus.DMEM_RValid = 1'b0;
            #4 check({tag, ".mis_stall"}, 32'(bus.Stall_Req), 0);
            cycle();
            idle();
            check({tag, ".mis"}, 32'(bus.Load_Misaligned), 1);
            check({tag, ".mis_en"}, 32'(bus.Reg_Write_Enable__EX_MEM), 0);
            #4 check({tag, ".mis_stall2"}, 32'(bus.Stall_Req), 0);
            cycle();
            check({tag, ".mis_pulse"}, 32'(bus.Load_Misaligned), 0);
            return;
        end
        for (int i = 0; i < lat; i++) begin
            bus.DMEM_RValid = 1'b0;
            bus.DMEM_RData  = $urandom;
            #4 check({tag, ".stall"}, 32'(bus.Stall_Req), 1);
            cycle();
        end
        bus.DMEM_RValid = 1'b1;
        bus.DMEM_RData  = word;
        #4 check({tag, ".stall_rel"}, 32'(bus.Stall_Req), 0);
        cycle();
        idle();
        check({tag, ".addr"}, 32'(bus.RD_Write_Addr), 32'(rd));
        check({tag, ".data"}, bus.RD_Write_Data, model_load(f3, addr, word));
        check({tag, ".en"}, 32'(bus.Reg_Write_Enable__EX_MEM), 32'(we && rd != 0));
        check({tag, ".irq"}, 32'(bus.WB_Ctrl__IRQ), 32'(irq));
        cycle();
        check({tag, ".en_off"}, 32'(bus.Reg_Write_Enable__EX_MEM), 0);
    endtask

    initial begin
        logic [2:0]  f3_tab [8];
        logic [1:0]  sel_tab [3];
        logic [31:0] d;
        f3_tab  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd4, 3'd7};
        sel_tab = '{2'b00, 2'b10, 2'b11};

        idle();
        drive_mem(1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 3'd0, 1'b0);
        bus.MEM_Valid = 1'b0;
        RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0;
        check("rst.addr", 32'(bus.RD_Write_Addr), 0);
        check("rst.data", bus.RD_Write_Data, 0);
        check("rst.en", 32'(bus.Reg_Write_Enable__EX_MEM), 0);
        check("rst.irq", 32'(bus.WB_Ctrl__IRQ), 0);
        check("rst.mis", 32'(bus.Load_Misaligned), 0);
        check("rst.stall", 32'(bus.Stall_Req), 0);
        check("rst.frz0", 32'(bus.MEM_WB_Freeze), 0);
        bus.Ext_Freeze = 1'b1;
        #1 check("rst.frz1", 32'(bus.MEM_WB_Freeze), 1);
        bus.Ext_Freeze = 1'b0;
        cycle();

        do_nonload("alu_rd5", 1'b1, 5'd5, 2'b00, 32'h1234, 32'h0, 1'b0);
        do_nonload("alu_rd0", 1'b1, 5'd0, 2'b00, 32'h1234, 32'h0, 1'b0);
        do_nonload("jal_pc4", 1'b1, 5'd1, 2'b10, 32'hDEAD, 32'h0000_1004, 1'b1);
        do_load("lb_off3", 1'b1, 5'd6, 3'd0, 32'h0000_2003, 32'h80FF_FF7F, 0, 1'b0);
        do_load("lbu_off3", 1'b1, 5'd6, 3'd4, 32'h0000_2003, 32'h80FF_FF7F, 1, 1'b0);
        do_load("lhu_off2", 1'b1, 5'd7, 3'd5, 32'h0000_2002, 32'h80FF_FF7F, 0, 1'b0);
        do_load("lw_late3", 1'b1, 5'd8, 3'd2, 32'h0000_3000, 32'hCAFE_BABE, 3, 1'b1);
        do_load("lw_mis", 1'b1, 5'd8, 3'd2, 32'h0000_0102, 32'h1111_2222, 0, 1'b0);

        // Back-to-back non-loads retire one per cycle.
        drive_mem(1'b1, 5'd3, 2'b00, 32'hAAAA_0001, 32'h0, 3'd0, 1'b0);
        cycle();
        drive_mem(1'b1, 5'd4, 2'b00, 32'hBBBB_0002, 32'h0, 3'd0, 1'b0);
        check("b2b.a_data", bus.RD_Write_Data, 32'hAAAA_0001);
        check("b2b.a_en", 32'(bus.Reg_Write_Enable__EX_MEM), 1);
        cycle();
        idle();
        check("b2b.b_addr", 32'(bus.RD_Write_Addr), 4);
        check("b2b.b_data", bus.RD_Write_Data, 32'hBBBB_0002);
        check("b2b.b_en", 32'(bus.Reg_Write_Enable__EX_MEM), 1);
        cycle();

        // Freeze held over a completed write: one enable cycle outside freeze.
        drive_mem(1'b1, 5'd12, 2'b00, 32'h0000_5A5A, 32'h0, 3'd0, 1'b0);
        cycle();
        idle();
        bus.Ext_Freeze = 1'b1;
        check("frz.en0", 32'(bus.Reg_Write_Enable__EX_MEM), 1);
        for (int i = 0; i < 3; i++) begin
            #4 check("frz.out", 32'(bus.MEM_WB_Freeze), 1);
            cycle();
            check("frz.en_hold", 32'(bus.Reg_Write_Enable__EX_MEM), 1);
            check("frz.data_hold", bus.RD_Write_Data, 32'h0000_5A5A);
        end
        cycle();
        bus.Ext_Freeze = 1'b0;
        check("frz.en_rel", 32'(bus.Reg_Write_Enable__EX_MEM), 1);
        #4 check("frz.out_rel", 32'(bus.MEM_WB_Freeze), 0);
        cycle();
        check("frz.en_once", 32'(bus.Reg_Write_Enable__EX_MEM), 0);

        // Response arriving during freeze is kept and written after release.
        d = 32'h1357_9BDF;
        drive_mem(1'b1, 5'd9, 2'b01, 32'h0000_0040, 32'h0, 3'd2, 1'b0);
        bus.DMEM_RValid = 1'b0;
        #4 check("frzld.stall", 32'(bus.Stall_Req), 1);
        cycle();
        bus.Ext_Freeze  = 1'b1;
        bus.DMEM_RValid = 1'b1;
        bus.DMEM_RData  = d;
        cycle();
        bus.DMEM_RValid = 1'b0;
        bus.DMEM_RData  = $urandom;
        for (int i = 0; i < 3; i++) begin
            check("frzld.en_hold", 32'(bus.Reg_Write_Enable__EX_MEM), 0);
            cycle();
        end
        bus.Ext_Freeze = 1'b0;
        #4 check("frzld.stall_rel", 32'(bus.Stall_Req), 0);
        cycle();
        idle();
        check("frzld.addr", 32'(bus.RD_Write_Addr), 9);
        check("frzld.data", bus.RD_Write_Data, d);
        check("frzld.en", 32'(bus.Reg_Write_Enable__EX_MEM), 1);
        cycle();
        check("frzld.en_off", 32'(bus.Reg_Write_Enable__EX_MEM), 0);

        // Flush during wait: stale response dropped, next load waits for it first.
        drive_mem(1'b1, 5'd10, 2'b01, 32'h0000_0080, 32'h0, 3'd2, 1'b0);
        bus.DMEM_RValid = 1'b0;
        cycle();
        bus.MEM_Valid = 1'b0;
        bus.Flush     = 1'b1;
        cycle();
        bus.Flush = 1'b0;
        check("flush.en", 32'(bus.Reg_Write_Enable__EX_MEM), 0);
        drive_mem(1'b1, 5'd11, 2'b01, 32'h0000_0084, 32'h0, 3'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #4 check("flush.disc_stall", 32'(bus.Stall_Req), 1);
            cycle();
        end
        bus.DMEM_RValid = 1'b1;
        bus.DMEM_RData  = 32'h5757_0000;
        #4 check("flush.stale_stall", 32'(bus.Stall_Req), 1);
        cycle();
        check("flush.stale_en", 32'(bus.Reg_Write_Enable__EX_MEM), 0);
        bus.DMEM_RValid = 1'b0;
        #4 check("flush.wait_stall", 32'(bus.Stall_Req), 1);
        cycle();
        bus.DMEM_RValid = 1'b1;
        bus.DMEM_RData  = 32'h0F0F_1234;
        #4 check("flush.new_stall", 32'(bus.Stall_Req), 0);
        cycle();
        idle();
        check("flush.new_addr", 32'(bus.RD_Write_Addr), 11);
        check("flush.new_data", bus.RD_Write_Data, 32'h0F0F_1234);
        check("flush.new_en", 32'(bus.Reg_Write_Enable__EX_MEM), 1);
        cycle();

        // Reset during wait clears outputs and drops the pending response.
        do_nonload("pre_rst", 1'b1, 5'd7, 2'b00, 32'h7777_7777, 32'h0, 1'b1);
        drive_mem(1'b1, 5'd13, 2'b01, 32'h0000_0100, 32'h0, 3'd2, 1'b1);
        bus.DMEM_RValid = 1'b0;
        cycle();
        bus.MEM_Valid = 1'b0;
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        check("wrst.addr", 32'(bus.RD_Write_Addr), 0);
        check("wrst.data", bus.RD_Write_Data, 0);
        check("wrst.irq", 32'(bus.WB_Ctrl__IRQ), 0);
        check("wrst.en", 32'(bus.Reg_Write_Enable__EX_MEM), 0);
        bus.DMEM_RValid = 1'b1;
        #4 check("wrst.stall", 32'(bus.Stall_Req), 0);
        cycle();
        idle();
        check("wrst.late_en", 32'(bus.Reg_Write_Enable__EX_MEM), 0);
        cycle();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1, 0) == 0) begin
                do_nonload("rnd_alu", 1'($urandom), 5'($urandom), sel_tab[$urandom_range(2, 0)],
                           $urandom, $urandom, 1'($urandom));
            end else begin
                do_load("rnd_ld", 1'($urandom), 5'($urandom), f3_tab[$urandom_range(7, 0)],
                        $urandom, $urandom, $urandom_range(3, 0), 1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-to-writeback pipeline stage of the RV32 core. It captures the retiring instruction from the MEM stage, aligns and sign-extends load data returned by data memory, and selects the write-back source. It drives the register file write port: address, data, enable, freeze and IRQ-bank select. It also stalls the pipeline while a load response is outstanding.

## Interface
- DATA_W, 32, datapath width; the design supports only 32.
- REG_AW, 5, register address width.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- MEM_Valid  in  1  MEM stage holds a valid instruction.
- MEM_Reg_Write  in  1  instruction writes rd.
- MEM_RD_Addr  in  5  destination register.
- MEM_WB_Sel  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- MEM_ALU_Result  in  32  ALU result; also the load address.
- MEM_PC_Plus4  in  32  link value.
- MEM_Load_Funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are treated as LW.
- MEM_IRQ  in  1  instruction executes in interrupt context, so it targets the shadow bank.
- DMEM_RData  in  32  data memory read word, word-aligned.
- DMEM_RValid  in  1  read data valid; single-cycle pulse.
- Flush  in  1  kill the instruction in MEM or WB.
- Ext_Freeze  in  1  downstream hold request.
- RD_Write_Addr  out  5  register file write address.
- RD_Write_Data  out  32  register file write data.
- Reg_Write_Enable__EX_MEM  out  1  write enable.
- WB_Ctrl__IRQ  out  1  write targets the shadow bank.
- MEM_WB_Freeze  out  1  equals Ext_Freeze (combinational); the register file suppresses writes while it is high.
- Stall_Req  out  1  upstream stages must hold; combinational.
- Load_Misaligned  out  1  one-cycle exception pulse.

## Operation
- FSM states:
  - IDLE: no load outstanding.
  - LOAD_WAIT: a load is outstanding; the captured rd, funct3, Addr_Lo and IRQ are held.
- Accept condition: MEM_Valid & ~Stall_Req & ~Ext_Freeze & ~Flush.
- On accept of a non-load:
  - WB register loads rd, IRQ and data (ALU or PC+4).
  - Enable = MEM_Reg_Write & (rd != 0).
- On accept of a load with an aligned address:
  - If DMEM_RValid is high in the same cycle, complete immediately as below.
  - Otherwise latch the context and enter LOAD_WAIT.
- Alignment and extension, with off = ALU[1:0]:
  - Byte = RData[8*off +: 8].
  - Half = RData[16*off[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Misaligned load: LH/LHU with off[0]=1, or LW with off≠0.
  - Load_Misaligned pulses for 1 cycle.
  - No write occurs and no wait is entered.
- LOAD_WAIT:
  - Stall_Req = ~DMEM_RValid.
  - On DMEM_RValid, write the aligned data to the WB register with Enable = Reg_Write & (rd≠0), then return to IDLE.
- Stall_Req in IDLE = MEM_Valid & load & aligned & ~DMEM_RValid & ~Flush.
- Ext_Freeze high:
  - WB outputs, FSM state and the latched context hold.
  - The register file write is blocked through MEM_WB_Freeze.
  - A DMEM_RValid arriving while frozen is captured into a one-entry holding register and consumed after release.
- Cycle with no accept and not frozen: Enable is cleared, so each instruction produces exactly one enable cycle outside freeze.
- Flush:
  - Clears WB Enable.
  - In LOAD_WAIT, returns to IDLE; the late DMEM_RValid is ignored (a discard flag is set until it arrives).
  - A new load must not be accepted while the discard flag is set.
- Priority: RST > Flush > Ext_Freeze > normal.

## Timing
- Reset values:
  - All outputs 0; FSM IDLE; holding and discard flags cleared.
  - Stall_Req = 0 and MEM_WB_Freeze = Ext_Freeze in the first cycle after reset.
- Non-load latency: 1 cycle from accept edge to outputs valid.
- Load latency: outputs valid on the edge after the DMEM_RValid cycle.
- Stall_Req and MEM_WB_Freeze are combinational. All other outputs are registered.
- Reset during LOAD_WAIT: IDLE on the next edge; a pending response is discarded.
- Back-to-back non-loads: one write per cycle, no bubbles.

## Test plan
- Aligned writes:
  - ALU op, rd=5, result 0x1234 → next cycle Addr=5, Data=0x1234, En=1 for exactly 1 cycle.
  - Same op with rd=0 → En=0.
- LB, off=3, RData=0x80FF_FF7F → Data 0xFFFF_FF80.
  - LBU in the same case → 0x0000_0080.
  - LHU with off=2 → 0x0000_80FF.
- LW with RValid 3 cycles late:
  - Stall_Req high for 3 cycles.
  - Write of RData on the edge after RValid; IRQ=1 propagates to WB_Ctrl__IRQ.
- LW with addr 0x102 → Load_Misaligned 1-cycle pulse, En=0, Stall_Req never high.
- Ext_Freeze held 4 cycles over a completed write:
  - Outputs hold and MEM_WB_Freeze=1.
  - After release: exactly one enable cycle, and no data lost from an RValid that arrived during the freeze.
- Flush and reset during LOAD_WAIT:
  - Flush → IDLE, the late RValid produces no write, and the next load stalls until the discard flag clears.
  - RST → all outputs 0 next cycle.
